// File: rtl/game_axil_slave_regs.sv
// AXI4-Lite slave exposing four 32-bit R/W registers to game logic.
// Independent write/read channels, one outstanding transaction each.
module game_axil_slave_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  output logic [3:0]                      reg_wr_pulse
);
  localparam int NumRegs  = 4;
  localparam int NumBytes = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {StWrIdle, StWrWaitW, StWrWaitA, StWrResp} wr_state_e;
  typedef enum logic {StRdIdle, StRdData} rd_state_e;

  wr_state_e                     r_wr_state;
  rd_state_e                     r_rd_state;
  logic                          r_awready, r_wready, r_bvalid;
  logic                          r_arready, r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [NumRegs];
  logic [1:0]                    r_aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
  logic [NumBytes-1:0]           r_wstrb;
  logic [NumRegs-1:0]            r_wr_pulse;

  logic                          w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [1:0]                    w_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data;
  logic [NumBytes-1:0]           w_strb;
  logic                          w_unused;

  assign w_aw_hs  = S_AXI_AWVALID & r_awready;
  assign w_w_hs   = S_AXI_WVALID & r_wready;
  assign w_ar_hs  = S_AXI_ARVALID & r_arready;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Commit source: live bus fields, or whichever half was latched while waiting.
  always_comb begin
    w_commit = 1'b0;
    w_idx    = S_AXI_AWADDR[3:2];
    w_data   = S_AXI_WDATA;
    w_strb   = S_AXI_WSTRB;
    case (r_wr_state)
      StWrIdle:  w_commit = w_aw_hs & w_w_hs;
      StWrWaitW: begin
        w_commit = w_w_hs;
        w_idx    = r_aw_idx;
      end
      StWrWaitA: begin
        w_commit = w_aw_hs;
        w_data   = r_wdata;
        w_strb   = r_wstrb;
      end
      default:   w_commit = 1'b0;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_wr_state <= StWrIdle;
      r_awready  <= 1'b1;
      r_wready   <= 1'b1;
      r_bvalid   <= 1'b0;
      r_wr_pulse <= '0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      for (int i = 0; i < NumRegs; i++) r_regs[i] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit) begin
        for (int b = 0; b < NumBytes; b++) begin
          if (w_strb[b]) r_regs[w_idx][8*b +: 8] <= w_data[8*b +: 8];
        end
        r_wr_pulse[w_idx] <= 1'b1;
      end
      case (r_wr_state)
        StWrIdle: begin
          if (w_aw_hs && w_w_hs) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_wr_state <= StWrResp;
          end else if (w_aw_hs) begin
            r_aw_idx   <= S_AXI_AWADDR[3:2];
            r_awready  <= 1'b0;
            r_wr_state <= StWrWaitW;
          end else if (w_w_hs) begin
            r_wdata    <= S_AXI_WDATA;
            r_wstrb    <= S_AXI_WSTRB;
            r_wready   <= 1'b0;
            r_wr_state <= StWrWaitA;
          end
        end
        StWrWaitW: begin
          if (w_w_hs) begin
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b1;
            r_wr_state <= StWrResp;
          end
        end
        StWrWaitA: begin
          if (w_aw_hs) begin
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b1;
            r_wr_state <= StWrResp;
          end
        end
        StWrResp: begin
          if (S_AXI_BREADY) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= StWrIdle;
          end
        end
        default: r_wr_state <= StWrIdle;
      endcase
    end
  end

  // Read samples r_regs before any same-edge commit lands, giving pre-write data.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      r_rd_state <= StRdIdle;
      r_arready  <= 1'b1;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        StRdIdle: begin
          if (w_ar_hs) begin
            r_rdata    <= r_regs[S_AXI_ARADDR[3:2]];
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rd_state <= StRdData;
          end
        end
        StRdData: begin
          if (S_AXI_RREADY) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= StRdIdle;
          end
        end
        default: r_rd_state <= StRdIdle;
      endcase
    end
  end

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_wready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign reg_out       = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign reg_wr_pulse  = r_wr_pulse;

endmodule

// File: tb/tb_game_axil_slave_regs.sv
// Self-checking bench for game_axil_slave_regs: directed vectors, corner
// sequences and randomized traffic against a byte-level register model.
module tb_game_axil_slave_regs;
  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic [3:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [3:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  game_axil_slave_regs dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [4];
  int pulse_bit_cnt [4];

  always @(negedge ACLK) begin
    for (int i = 0; i < 4; i++) if (reg_wr_pulse[i]) pulse_bit_cnt[i]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    for (int b = 0; b < 4; b++) if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
  endtask

  function automatic logic [127:0] model_packed();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic wait_b(input int b_dly);
    int n;
    bit got, now;
    logic [1:0] resp;
    n = 0; got = 0; resp = 2'bxx;
    while (!got && n < 40) begin
      S_AXI_BREADY = (n >= b_dly);
      @(negedge ACLK);
      now = S_AXI_BVALID && S_AXI_BREADY;
      if (now) resp = S_AXI_BRESP;
      @(posedge ACLK); #1;
      got = now;
      n++;
    end
    S_AXI_BREADY = 1'b0;
    chk("b_handshake", got, 1'b1);
    chk("bresp", resp, 2'b00);
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int n, snap[4], others;
    bit aw_done, w_done, aw_now, w_now;
    for (int i = 0; i < 4; i++) snap[i] = pulse_bit_cnt[i];
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 40) begin
      S_AXI_AWVALID = !aw_done && (n >= aw_dly);
      S_AXI_WVALID  = !w_done && (n >= w_dly);
      @(negedge ACLK);
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); #1;
      aw_done |= aw_now;
      w_done  |= w_now;
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("wr_addr_data_accept", {aw_done, w_done}, 2'b11);
    model_write(addr, data, strb);
    wait_b(b_dly);
    others = 0;
    for (int i = 0; i < 4; i++) if (i != int'(addr[3:2])) others += pulse_bit_cnt[i] - snap[i];
    chk("wr_pulse_own", pulse_bit_cnt[addr[3:2]] - snap[addr[3:2]], 1);
    chk("wr_pulse_others", others, 0);
    chk("wr_reg_out", reg_out, model_packed());
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_dly, output logic [31:0] data);
    int n;
    bit done, now;
    logic [1:0] resp;
    S_AXI_ARADDR = addr; done = 0; n = 0;
    while (!done && n < 40) begin
      S_AXI_ARVALID = 1'b1;
      @(negedge ACLK);
      now = S_AXI_ARREADY;
      @(posedge ACLK); #1;
      done = now;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("ar_accept", done, 1'b1);
    done = 0; n = 0; data = 'x; resp = 2'bxx;
    while (!done && n < 40) begin
      S_AXI_RREADY = (n >= r_dly);
      @(negedge ACLK);
      now = S_AXI_RVALID && S_AXI_RREADY;
      if (now) begin data = S_AXI_RDATA; resp = S_AXI_RRESP; end
      @(posedge ACLK); #1;
      done = now;
      n++;
    end
    S_AXI_RREADY = 1'b0;
    chk("r_handshake", done, 1'b1);
    chk("rresp", resp, 2'b00);
  endtask

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[9];
  logic [31:0] rd;
  logic [3:0]  ra, rs;
  logic [31:0] rdat;

  initial begin
    vecs[0] = '{4'h0, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{4'h4, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{4'h8, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{4'hC, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{4'h4, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF};
    vecs[5] = '{4'h4, 32'h1234_5678, 4'h5, 32'hFF34_FF78};
    vecs[6] = '{4'h6, 32'h0000_0000, 4'h0, 32'hFF34_FF78};
    vecs[7] = '{4'hF, 32'hAABB_CCDD, 4'h8, 32'hAA00_0004};
    vecs[8] = '{4'h3, 32'h0000_9900, 4'h2, 32'h0000_9901};

    ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rst_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    chk("rst_valids", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_reg_out", reg_out, 128'h0);
    chk("rst_pulse", reg_wr_pulse, 4'h0);
    @(posedge ACLK); #1;

    // Directed vectors: write, then read back
    for (int i = 0; i < 9; i++) begin
      do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0);
      do_read(vecs[i].addr, 0, rd);
      chk("vec_readback", rd, vecs[i].exp);
      if (i == 3) chk("vec_reg_out_all", reg_out, 128'h00000004_00000003_00000002_00000001);
    end

    // AW three cycles ahead of W
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("awfirst_wait", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b010);
    end
    S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
    model_write(4'h8, 32'hDEAD_BEEF, 4'hF);
    @(negedge ACLK);
    chk("awfirst_bvalid", S_AXI_BVALID, 1'b1);
    chk("awfirst_pulse", reg_wr_pulse, 4'b0100);
    chk("awfirst_reg_out", reg_out, model_packed());
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    chk("awfirst_after", {S_AXI_BVALID, reg_wr_pulse}, 5'b0_0000);
    @(posedge ACLK); #1;

    // W three cycles ahead of AW
    S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1 S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      chk("wfirst_wait", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
    end
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
    model_write(4'h0, 32'hCAFE_F00D, 4'hF);
    @(negedge ACLK);
    chk("wfirst_bvalid", S_AXI_BVALID, 1'b1);
    chk("wfirst_pulse", reg_wr_pulse, 4'b0001);
    chk("wfirst_reg_out", reg_out, model_packed());
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;

    // BREADY stall blocks a second write
    S_AXI_AWADDR = 4'hC; S_AXI_WDATA = 32'h0000_0001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    model_write(4'hC, 32'h0000_0001, 4'hF);
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h0000_0077;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("bstall_hold", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1 S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    chk("bstall_release", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b011);
    chk("bstall_no_early_commit", reg_out, model_packed());
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    model_write(4'h0, 32'h0000_0077, 4'hF);
    wait_b(0);
    chk("bstall_second", reg_out, model_packed());

    // RREADY stall keeps RDATA stable
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1 S_AXI_ARVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("rstall_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA}, {2'b10, model[3]});
    end
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1 S_AXI_RREADY = 1'b0;
    @(negedge ACLK);
    chk("rstall_release", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);
    @(posedge ACLK); #1;

    // Same-edge read and write of reg2
    do_write(4'h8, 32'h0000_000A, 4'hF, 0, 0, 1);
    S_AXI_AWADDR = 4'h8; S_AXI_WDATA = 32'h0000_000B; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'h8;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    @(negedge ACLK);
    chk("rw_same_rdata_old", {S_AXI_RVALID, S_AXI_BVALID, S_AXI_RDATA}, {2'b11, 32'h0000_000A});
    model_write(4'h8, 32'h0000_000B, 4'hF);
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
    do_read(4'h8, 0, rd);
    chk("rw_same_next_read", rd, 32'h0000_000B);

    // Reset while waiting for W
    do_write(4'h0, 32'h0000_0055, 4'hF, 0, 0, 0);
    S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1 S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    chk("rstmid_waitw", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
    ARESETN = 1'b0;
    @(posedge ACLK); #1 ARESETN = 1'b1;
    for (int i = 0; i < 4; i++) model[i] = '0;
    @(negedge ACLK);
    chk("rstmid_readies", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    chk("rstmid_regs", reg_out, 128'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("rstmid_no_bvalid", {S_AXI_BVALID, reg_wr_pulse}, 5'b0_0000);
    end
    @(posedge ACLK); #1;

    // Randomized traffic against the model
    for (int k = 0; k < 150; k++) begin
      ra = 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        rdat = $urandom;
        rs   = 4'($urandom);
        do_write(ra, rdat, rs, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        do_read(ra, $urandom_range(0, 3), rd);
        chk("rand_read", rd, model[ra[3:2]]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
